thumb_inst_align: RTL and testbench

Halfword alignment and instruction-assembly buffer between Thumb instruction fetch and decode in the ARMv7-M core. It accepts 32-bit little-endian fetch words and assembles them into complete 16-bit or 32-bit Thumb instructions, including 32-bit instructions that straddle two fetch words. For T32 data-processing modified-immediate instructions it extracts the 12-bit `imm12` field. Decode feeds that field to the immediate expander unchanged.

---
 rtl/thumb_inst_align_if.sv | 23 ++
 rtl/thumb_inst_align.sv | 97 +++++++++
 tb/tb_thumb_inst_align.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/thumb_inst_align_if.sv
// Fetch-side and decode-side handshakes of the Thumb halfword alignment buffer.
// The slave modport is the buffer's view; the master modport is the fetch/decode view.
interface thumb_inst_align_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_is32;
  logic        dp_imm_valid;
  logic [11:0] imm12;

  modport slave (
    input  fetch_valid, fetch_data, inst_ready,
    output fetch_ready, inst_valid, inst, inst_is32, dp_imm_valid, imm12
  );

  modport master (
    output fetch_valid, fetch_data, inst_ready,
    input  fetch_ready, inst_valid, inst, inst_is32, dp_imm_valid, imm12
  );
endinterface

// File: rtl/thumb_inst_align.sv
// Assembles 32-bit fetch words into 16/32-bit Thumb instructions via a circular halfword buffer.
// Define THUMB_IMM_DECODE_EN to generate dp_imm_valid/imm12; otherwise both are tied to 0.
module thumb_inst_align #(
  parameter int HW_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             flush_hw1,
  thumb_inst_align_if.slave bus
);
  localparam int PW = (HW_DEPTH > 1) ? $clog2(HW_DEPTH) : 1;
  localparam int CW = $clog2(HW_DEPTH + 1);

  logic [HW_DEPTH-1:0][15:0] buf_q;
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      skip_q, skip_d;
  logic [15:0]               hw1, hw2;
  logic                      is32, push, pop;
  logic [1:0]                push_n, pop_n;

  // Pointer advance by 0..2 with wrap for any depth (not just powers of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= HW_DEPTH) s = s - HW_DEPTH;
    return PW'(s);
  endfunction

  assign hw1  = buf_q[head_q];
  assign hw2  = buf_q[ptr_add(head_q, 2'd1)];
  assign is32 = (hw1[15:13] == 3'b111) && (hw1[12:11] != 2'b00);

  assign bus.fetch_ready = !rst && !flush && (count_q <= CW'(HW_DEPTH - 2));
  assign bus.inst_valid  = !rst && (count_q != '0) && (!is32 || count_q >= CW'(2));

  assign push   = bus.fetch_valid && bus.fetch_ready;
  // A pop handshake during flush is consumed by decode but leaves the buffer alone.
  assign pop    = bus.inst_valid && bus.inst_ready && !flush;
  assign push_n = !push ? 2'd0 : (skip_q ? 2'd1 : 2'd2);
  assign pop_n  = !pop  ? 2'd0 : (is32   ? 2'd2 : 2'd1);

  always_comb begin
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    head_d  = ptr_add(head_q, pop_n);
    tail_d  = ptr_add(tail_q, push_n);
    skip_d  = push ? 1'b0 : skip_q;
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      skip_d  = flush_hw1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      skip_q  <= skip_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      if (skip_q) begin
        buf_q[tail_q] <= bus.fetch_data[31:16];
      end else begin
        buf_q[tail_q]                <= bus.fetch_data[15:0];
        buf_q[ptr_add(tail_q, 2'd1)] <= bus.fetch_data[31:16];
      end
    end
  end

  always_comb begin
    bus.inst         = 32'h0;
    bus.inst_is32    = 1'b0;
    bus.dp_imm_valid = 1'b0;
    bus.imm12        = 12'h0;
    if (bus.inst_valid) begin
      bus.inst      = is32 ? {hw1, hw2} : {16'h0, hw1};
      bus.inst_is32 = is32;
`ifdef THUMB_IMM_DECODE_EN
      bus.dp_imm_valid = is32 && (hw1[15:11] == 5'b11110) && !hw1[9] && !hw2[15];
      bus.imm12        = {hw1[10], hw2[14:12], hw2[7:0]};
`endif
    end
  end
endmodule

// File: tb/tb_thumb_inst_align.sv
// Randomized + directed bench for thumb_inst_align against a halfword-queue model.
module tb_thumb_inst_align;
  localparam int D = 4;
`ifdef THUMB_IMM_DECODE_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush_hw1 = 1'b0;
  thumb_inst_align_if bus();

  thumb_inst_align #(.HW_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_hw1(flush_hw1), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] q[$];
  bit          skip = 1'b0;

  function automatic bit m_is32();
    return q.size() > 0 && (q[0][15:11] inside {5'b11101, 5'b11110, 5'b11111});
  endfunction

  function automatic bit m_iv();
    return !rst && q.size() > 0 && (!m_is32() || q.size() >= 2);
  endfunction

  // {fetch_ready, inst_valid, inst, inst_is32, dp_imm_valid, imm12}
  function automatic logic [47:0] m_out();
    logic        fr, dp;
    logic [31:0] ins;
    logic [11:0] imm;
    fr  = !rst && !flush && (q.size() <= D - 2);
    ins = 32'h0;
    dp  = 1'b0;
    imm = 12'h0;
    if (m_iv()) begin
      if (m_is32()) begin
        ins = {q[0], q[1]};
        if (IMM_EN) begin
          dp  = (q[0][15:11] == 5'b11110) && !q[0][9] && !q[1][15];
          imm = {q[0][10], q[1][14:12], q[1][7:0]};
        end
      end else begin
        ins = {16'h0, q[0]};
      end
    end
    return {fr, m_iv(), ins, m_iv() && m_is32(), dp, imm};
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  sz, n;
    bit  do_pop, do_push;
    sz      = q.size();
    n       = m_is32() ? 2 : 1;
    do_pop  = m_iv() && bus.inst_ready;
    do_push = bus.fetch_valid && !flush && (sz <= D - 2);
    if (rst) begin
      q.delete();
      skip = 1'b0;
    end else if (flush) begin
      q.delete();
      skip = flush_hw1;
    end else begin
      if (do_pop) repeat (n) void'(q.pop_front());
      if (do_push) begin
        if (!skip) q.push_back(bus.fetch_data[15:0]);
        q.push_back(bus.fetch_data[31:16]);
        skip = 1'b0;
      end
    end
  end

  always @(negedge clk)
    check("cycle", {bus.fetch_ready, bus.inst_valid, bus.inst, bus.inst_is32,
                    bus.dp_imm_valid, bus.imm12}, m_out());

  task automatic apply(input bit r, input bit fv, input logic [31:0] fd, input bit ir,
                       input bit fl, input bit fh);
    @(posedge clk);
    #1;
    rst             = r;
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.inst_ready  = ir;
    flush           = fl;
    flush_hw1       = fh;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       h[15:11] = 5'b11110;
      1:       h[15:13] = 3'b111;
      default: ;
    endcase
    return h;
  endfunction

  initial begin
    bit          fv, hold, r, fl;
    logic [31:0] fd;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 32'h0;
    bus.inst_ready  = 1'b0;
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);

    // two 16-bit instructions
    apply(0, 1, 32'h2001_2102, 1, 0, 0);
    check("t1_fr", 48'(bus.fetch_ready), 48'h1);
    check("t1_iv0", 48'(bus.inst_valid), 48'h0);
    apply(0, 0, 0, 1, 0, 0);
    check("t1_a", {15'h0, bus.inst_is32, bus.inst}, 48'h0000_0000_2102);
    apply(0, 0, 0, 1, 0, 0);
    check("t1_b", 48'(bus.inst), 48'h2001);
    apply(0, 0, 0, 1, 0, 0);
    check("t1_empty", 48'(bus.inst_valid), 48'h0);

    // MOV.W modified immediate
    apply(0, 1, 32'h00FF_F04F, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    check("t2_inst", {15'h0, bus.inst_is32, bus.inst}, 48'h0001_F04F_00FF);
    check("t2_dp", {35'h0, bus.dp_imm_valid, bus.imm12}, {35'h0, IMM_EN, IMM_EN ? 12'h0FF : 12'h0});
    apply(0, 1, 32'h70FF_F44F, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    check("t2b_inst", 48'(bus.inst), 48'hF44F_70FF);
    check("t2b_imm", 48'(bus.imm12), IMM_EN ? 48'hFFF : 48'h0);

    // straddling 32-bit instruction
    apply(0, 1, 32'hF04F_BF00, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    check("t3_bf00", 48'(bus.inst), 48'hBF00);
    apply(0, 0, 0, 1, 0, 0);
    check("t3_half_wait", 48'(bus.inst_valid), 48'h0);
    apply(0, 1, 32'h2001_00FF, 1, 0, 0);
    check("t3_still_wait", 48'(bus.inst_valid), 48'h0);
    apply(0, 0, 0, 1, 0, 0);
    check("t3_w", 48'(bus.inst), 48'hF04F_00FF);
    check("t3_dp", {35'h0, bus.dp_imm_valid, bus.imm12}, {35'h0, IMM_EN, IMM_EN ? 12'h0FF : 12'h0});
    apply(0, 0, 0, 1, 0, 0);
    check("t3_2001", 48'(bus.inst), 48'h2001);

    // flush to odd halfword
    apply(0, 1, 32'h2001_2102, 0, 0, 0);
    apply(0, 1, 32'hBF00_BF00, 1, 0, 0);
    apply(0, 1, 32'hDEAD_BEEF, 0, 1, 1);
    check("t4_flush_fr", 48'(bus.fetch_ready), 48'h0);
    apply(0, 1, 32'h2001_BF00, 1, 0, 0);
    check("t4_empty", {46'h0, bus.fetch_ready, bus.inst_valid}, 48'h2);
    apply(0, 0, 0, 1, 0, 0);
    check("t4_only", {16'h0, bus.inst}, 48'h2001);
    apply(0, 0, 0, 1, 0, 0);
    check("t4_done", 48'(bus.inst_valid), 48'h0);

    // backpressure and full
    apply(0, 1, 32'h2001_2102, 0, 0, 0);
    apply(0, 1, 32'h2004_2003, 0, 0, 0);
    check("t5_fr2", 48'(bus.fetch_ready), 48'h1);
    apply(0, 0, 0, 0, 0, 0);
    check("t5_full", {15'h0, bus.fetch_ready, bus.inst}, 48'h0000_0000_2102);
    apply(0, 0, 0, 0, 0, 0);
    check("t5_hold", 48'(bus.inst), 48'h2102);
    apply(0, 0, 0, 1, 0, 0);
    check("t5_d0", {15'h0, bus.fetch_ready, bus.inst}, 48'h0000_0000_2102);
    apply(0, 0, 0, 1, 0, 0);
    check("t5_d1", {15'h0, bus.fetch_ready, bus.inst}, 48'h0000_0000_2001);
    apply(0, 0, 0, 1, 0, 0);
    check("t5_d2", {15'h0, bus.fetch_ready, bus.inst}, 48'h0001_0000_2003);
    apply(0, 0, 0, 1, 0, 0);
    check("t5_d3", {15'h0, bus.fetch_ready, bus.inst}, 48'h0001_0000_2004);
    apply(0, 0, 0, 1, 0, 0);
    check("t5_end", 48'(bus.inst_valid), 48'h0);

    // reset mid-stream
    apply(0, 1, 32'h2001_2102, 0, 0, 0);
    apply(0, 1, 32'h2004_2003, 1, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    check("t6_rst", {14'h0, bus.fetch_ready, bus.inst_valid, bus.inst}, 48'h0);
    apply(0, 1, 32'h2001_BF00, 1, 0, 0);
    check("t6_after", {46'h0, bus.fetch_ready, bus.inst_valid}, 48'h2);
    apply(0, 0, 0, 1, 0, 0);
    check("t6_a", 48'(bus.inst), 48'hBF00);
    apply(0, 0, 0, 1, 0, 0);
    check("t6_b", 48'(bus.inst), 48'h2001);

    // randomized traffic against the queue model
    hold = 1'b0;
    fv   = 1'b0;
    fd   = 32'h0;
    repeat (3000) begin
      r  = ($urandom_range(0, 99) == 0);
      fl = !r && ($urandom_range(0, 39) == 0);
      if (!hold) begin
        fv = ($urandom_range(0, 2) != 0);
        fd = {rand_hw(), rand_hw()};
      end
      apply(r, fv, fd, $urandom_range(0, 3) != 0, fl, 1'($urandom_range(0, 1)));
      hold = fv && !bus.fetch_ready && !fl && !r;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
